// File: rtl/imem_access_ctrl.sv
// Instruction-memory access controller.
// Boots by reading the start PC from the first memory word, then shares the
// single memory port between the fetch stage and the loader/debug port.
// The loader has priority, but its burst length is capped while fetch waits,
// so fetch always makes progress.
module imem_access_ctrl #(
  parameter logic [31:0] ADDR_BASE    = 32'h0010_0000,
  parameter int          DEPTH_WORDS  = 1025,
  parameter int          MAX_LD_BURST = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  // fetch requester
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_grant,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_fault,
  // loader / debug requester
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_grant,
  output logic [31:0] ld_rdata,
  output logic        ld_rvalid,
  // boot status
  output logic        boot_done,
  output logic [31:0] start_pc,
  // memory port
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int               CNT_W     = $clog2(MAX_LD_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_LD_BURST);
  // One past the last valid byte address; 33 bits so a region ending at
  // the top of the address space cannot wrap.
  localparam logic [32:0]      ADDR_END  = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
  localparam logic [31:0]      BOOT_WORD = {2'b00, ADDR_BASE[31:2]};

  typedef enum logic [1:0] {
    BOOT0 = 2'd0,
    BOOT1 = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

  // Grant-cycle decisions (combinational on the current requests)
  logic        fetch_grant_p0;
  logic        ld_grant_p0;
  logic        fetch_bad_p0;
  logic        ld_bad_p0;
  logic        boot_capture_p0;
  logic [31:0] mem_addr_p0;
  logic        mem_we_p0;
  logic [31:0] mem_wdata_p0;

  // Registered read results, one cycle after the grant
  logic        fetch_vld_p1;
  logic        fetch_fault_p1;
  logic [31:0] fetch_instr_p1;
  logic        ld_vld_p1;
  logic [31:0] ld_rdata_p1;
  logic        boot_done_q;
  logic [31:0] start_pc_q;

  // Misaligned, below the base, or past the last word.
  function automatic logic addr_bad(input logic [31:0] addr);
    logic [32:0] addr_x;
    addr_x = {1'b0, addr};
    return (addr[1:0] != 2'b00) ||
           (addr_x < {1'b0, ADDR_BASE}) ||
           (addr_x >= ADDR_END);
  endfunction

  // Burst counter increment that sticks at the cap.
  function automatic logic [CNT_W-1:0] burst_sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt >= CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  endfunction

  // Byte address to memory word index.
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // Next-state, arbitration and memory-port drive for the current cycle.
  always_comb begin
    state_nxt       = state;
    burst_cnt_nxt   = '0;
    fetch_grant_p0  = 1'b0;
    ld_grant_p0     = 1'b0;
    boot_capture_p0 = 1'b0;
    mem_addr_p0     = '0;
    mem_we_p0       = 1'b0;
    mem_wdata_p0    = '0;
    fetch_bad_p0    = addr_bad(fetch_addr);
    ld_bad_p0       = addr_bad(ld_addr);

    case (state)
      BOOT0: begin
        // Let the memory's own init cycle elapse before sampling word 0.
        mem_addr_p0 = BOOT_WORD;
        state_nxt   = BOOT1;
      end

      BOOT1: begin
        mem_addr_p0     = BOOT_WORD;
        boot_capture_p0 = 1'b1;
        state_nxt       = RUN;
      end

      RUN: begin
        // Loader wins unless it has used up its burst while fetch waits.
        ld_grant_p0    = ld_req && !(fetch_req && (burst_cnt == CNT_MAX));
        fetch_grant_p0 = fetch_req && !ld_grant_p0;

        if (ld_grant_p0) begin
          mem_addr_p0 = word_index(ld_addr);
          if (ld_we && !ld_bad_p0) begin
            mem_we_p0    = 1'b1;
            mem_wdata_p0 = ld_wdata;
          end
        end else if (fetch_grant_p0) begin
          mem_addr_p0 = word_index(fetch_addr);
        end

        // Count loader grants only while fetch is actually waiting.
        if (!fetch_req || fetch_grant_p0) begin
          burst_cnt_nxt = '0;
        end else if (ld_grant_p0) begin
          burst_cnt_nxt = burst_sat_inc(burst_cnt);
        end else begin
          burst_cnt_nxt = burst_cnt;
        end
      end

      default: begin
        state_nxt = BOOT0;
      end
    endcase
  end

  // Control state: FSM, burst counter, boot flag and read-valid pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= BOOT0;
      burst_cnt      <= '0;
      boot_done_q    <= 1'b0;
      fetch_vld_p1   <= 1'b0;
      fetch_fault_p1 <= 1'b0;
      ld_vld_p1      <= 1'b0;
    end else begin
      state          <= state_nxt;
      burst_cnt      <= burst_cnt_nxt;
      boot_done_q    <= boot_done_q || boot_capture_p0;
      fetch_vld_p1   <= fetch_grant_p0;
      fetch_fault_p1 <= fetch_grant_p0 && fetch_bad_p0;
      ld_vld_p1      <= ld_grant_p0 && !ld_we;
    end
  end

  // ---- stage p0 -> p1: capture read data in the grant cycle ----
  // Data registers are also cleared so every output reads zero in reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_instr_p1 <= '0;
      ld_rdata_p1    <= '0;
      start_pc_q     <= '0;
    end else begin
      if (fetch_grant_p0) begin
        fetch_instr_p1 <= fetch_bad_p0 ? 32'h0 : mem_rdata;
      end
      if (ld_grant_p0 && !ld_we) begin
        ld_rdata_p1 <= ld_bad_p0 ? 32'h0 : mem_rdata;
      end
      // Only the boot sequence loads start_pc; later writes to word 0 do not.
      if (boot_capture_p0) begin
        start_pc_q <= mem_rdata;
      end
    end
  end

  // Combinational port drives are forced low while reset is held.
  assign fetch_grant = reset_n && fetch_grant_p0;
  assign ld_grant    = reset_n && ld_grant_p0;
  assign mem_addr    = reset_n ? mem_addr_p0 : 32'h0;
  assign mem_we      = reset_n && mem_we_p0;
  assign mem_wdata   = reset_n ? mem_wdata_p0 : 32'h0;

  assign fetch_valid = fetch_vld_p1;
  assign fetch_fault = fetch_fault_p1;
  assign fetch_instr = fetch_instr_p1;
  assign ld_rvalid   = ld_vld_p1;
  assign ld_rdata    = ld_rdata_p1;
  assign boot_done   = boot_done_q;
  assign start_pc    = start_pc_q;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl: behavioural memory, reset/boot checks,
// a table of single-cycle transactions, and hand sequences for burst
// arbitration and reset in the middle of a read.
module tb_imem_access_ctrl;

  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int          DEPTH = 1025;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_grant, fetch_valid, fetch_fault;
  logic [31:0] fetch_instr;
  logic        ld_req = 1'b0;
  logic        ld_we = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_wdata = '0;
  logic        ld_grant, ld_rvalid;
  logic [31:0] ld_rdata;
  logic        boot_done;
  logic [31:0] start_pc;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  imem_access_ctrl #(
    .ADDR_BASE   (BASE),
    .DEPTH_WORDS (DEPTH),
    .MAX_LD_BURST(4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_grant(fetch_grant),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .fetch_fault(fetch_fault),
    .ld_req     (ld_req),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_grant   (ld_grant),
    .ld_rdata   (ld_rdata),
    .ld_rvalid  (ld_rvalid),
    .boot_done  (boot_done),
    .start_pc   (start_pc),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural memory: word 0 = start PC, word i = A000_0000 + i.
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] mem_idx;
  logic        mem_hit;
  logic        mem_init = 1'b0;
  logic        poke_en = 1'b0;
  logic [31:0] poke_val = '0;

  always_comb begin
    mem_idx   = mem_addr - (BASE >> 2);
    mem_hit   = (mem_addr >= (BASE >> 2)) && (mem_idx < 32'(DEPTH));
    mem_rdata = mem_hit ? mem[mem_idx[10:0]] : 32'h0;
  end

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i == 0) ? 32'h0040_0000 : 32'hA000_0000 + 32'(i);
      mem_init <= 1'b1;
    end else if (poke_en) begin
      mem[0] <= poke_val;
    end else if (mem_we && mem_hit) begin
      mem[mem_idx[10:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " fetch_grant"}, 32'(fetch_grant), 32'h0);
    chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'h0);
    chk({tag, " fetch_fault"}, 32'(fetch_fault), 32'h0);
    chk({tag, " fetch_instr"}, fetch_instr, 32'h0);
    chk({tag, " ld_grant"},    32'(ld_grant), 32'h0);
    chk({tag, " ld_rvalid"},   32'(ld_rvalid), 32'h0);
    chk({tag, " ld_rdata"},    ld_rdata, 32'h0);
    chk({tag, " boot_done"},   32'(boot_done), 32'h0);
    chk({tag, " start_pc"},    start_pc, 32'h0);
    chk({tag, " mem_addr"},    mem_addr, 32'h0);
    chk({tag, " mem_we"},      32'(mem_we), 32'h0);
    chk({tag, " mem_wdata"},   mem_wdata, 32'h0);
  endtask

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        e_fg;   // fetch_grant this cycle
    logic        e_lg;   // ld_grant this cycle
    logic        e_we;   // mem_we this cycle
    logic        e_fv;   // fetch_valid next cycle
    logic        e_ff;   // fetch_fault next cycle
    logic [31:0] e_fi;   // fetch_instr next cycle
    logic        e_lv;   // ld_rvalid next cycle
    logic [31:0] e_ld;   // ld_rdata next cycle
  } vec_t;

  vec_t vecs[16];

  task automatic set_idle();
    fetch_req = 1'b0; fetch_addr = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
  endtask

  task automatic apply(input vec_t v, input int k);
    @(negedge clock);
    fetch_req = v.f_req; fetch_addr = v.f_addr;
    ld_req = v.l_req; ld_we = v.l_we; ld_addr = v.l_addr; ld_wdata = v.l_wdata;
    #1;
    chk($sformatf("v%0d fetch_grant", k), 32'(fetch_grant), 32'(v.e_fg));
    chk($sformatf("v%0d ld_grant", k),    32'(ld_grant), 32'(v.e_lg));
    chk($sformatf("v%0d mem_we", k),      32'(mem_we), 32'(v.e_we));
    if (v.e_we) begin
      chk($sformatf("v%0d mem_addr", k),  mem_addr, v.l_addr >> 2);
      chk($sformatf("v%0d mem_wdata", k), mem_wdata, v.l_wdata);
    end
    @(posedge clock);
    #1;
    chk($sformatf("v%0d fetch_valid", k), 32'(fetch_valid), 32'(v.e_fv));
    if (v.e_fv) begin
      chk($sformatf("v%0d fetch_fault", k), 32'(fetch_fault), 32'(v.e_ff));
      chk($sformatf("v%0d fetch_instr", k), fetch_instr, v.e_fi);
    end
    chk($sformatf("v%0d ld_rvalid", k), 32'(ld_rvalid), 32'(v.e_lv));
    if (v.e_lv) chk($sformatf("v%0d ld_rdata", k), ld_rdata, v.e_ld);
  endtask

  initial begin
    int f_cnt;
    int ld_run;
    int ld_run_max;

    //             f_req  f_addr        l_req l_we  l_addr        l_wdata       fg    lg    we    fv    ff    fi            lv    ld
    vecs[0]  = '{1'b1, 32'h0010_0004, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0001, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h0010_0008, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0002, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0010_000C, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0003};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0010_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h0010_0010, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h0010_0002, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0020_0000, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0020_0000, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[10] = '{1'b1, 32'h0010_1000, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0400, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h0010_1004, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0010_0000, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0000};
    vecs[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0010_0000, 32'hCAFE_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0};
    vecs[14] = '{1'b1, 32'h0010_0004, 1'b1, 1'b0, 32'h0010_0008, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0002};
    vecs[15] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0};

    // Reset with both requesters active: everything must read zero.
    fetch_req = 1'b1; fetch_addr = BASE + 32'd4;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = BASE + 32'd8; ld_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");

    // Boot: two cycles, no grants, requests ignored.
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("boot0 fetch_grant", 32'(fetch_grant), 32'h0);
    chk("boot0 ld_grant",    32'(ld_grant), 32'h0);
    chk("boot0 mem_we",      32'(mem_we), 32'h0);
    chk("boot0 mem_addr",    mem_addr, 32'h0004_0000);
    @(posedge clock); #1;
    chk("boot1 boot_done",   32'(boot_done), 32'h0);
    chk("boot1 fetch_grant", 32'(fetch_grant), 32'h0);
    chk("boot1 ld_grant",    32'(ld_grant), 32'h0);
    chk("boot1 mem_addr",    mem_addr, 32'h0004_0000);
    @(posedge clock); #1;
    chk("boot boot_done",    32'(boot_done), 32'h1);
    chk("boot start_pc",     start_pc, 32'h0040_0000);
    chk("boot no fetch_valid", 32'(fetch_valid), 32'h0);
    set_idle();

    // Single-cycle transaction table.
    for (int k = 0; k < 16; k++) apply(vecs[k], k);
    chk("start_pc after word0 write", start_pc, 32'h0040_0000);

    // Contention: both held; 4 loader grants then 1 fetch grant, repeating.
    f_cnt = 0; ld_run = 0; ld_run_max = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      fetch_req = 1'b1; fetch_addr = BASE + 32'd4;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = BASE + 32'd8;
      #1;
      chk($sformatf("burst%0d ld_grant", i),    32'(ld_grant), 32'((i % 5) != 4));
      chk($sformatf("burst%0d fetch_grant", i), 32'(fetch_grant), 32'((i % 5) == 4));
      if (fetch_grant) begin
        f_cnt++;
        ld_run = 0;
      end else if (ld_grant) begin
        ld_run++;
        if (ld_run > ld_run_max) ld_run_max = ld_run;
      end
      @(posedge clock); #1;
      chk($sformatf("burst%0d fetch_valid", i), 32'(fetch_valid), 32'((i % 5) == 4));
    end
    chk("burst fetch grants", 32'(f_cnt), 32'd3);
    chk("burst longest loader run", 32'(ld_run_max), 32'd4);
    @(negedge clock);
    set_idle();

    // Reset while a granted fetch is in flight: no valid, boot repeats.
    @(negedge clock);
    fetch_req = 1'b1; fetch_addr = BASE + 32'd4;
    #1;
    chk("midrst fetch_grant", 32'(fetch_grant), 32'h1);
    #3;
    reset_n = 1'b0;
    set_idle();
    @(posedge clock); #1;
    chk("midrst fetch_valid", 32'(fetch_valid), 32'h0);
    chk_all_zero("midrst");
    @(negedge clock);
    poke_en = 1'b1; poke_val = 32'h0050_0000;
    @(posedge clock); #1;
    poke_en = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("reboot1 boot_done", 32'(boot_done), 32'h0);
    @(posedge clock); #1;
    chk("reboot boot_done", 32'(boot_done), 32'h1);
    chk("reboot start_pc",  start_pc, 32'h0050_0000);
    @(negedge clock);
    fetch_req = 1'b1; fetch_addr = BASE + 32'd8;
    @(posedge clock); #1;
    chk("reboot fetch_valid", 32'(fetch_valid), 32'h1);
    chk("reboot fetch_instr", fetch_instr, 32'hA000_0002);
    set_idle();

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Sequences boot and arbitrates access to the single-port instruction memory.
- Requesters are the fetch stage (reads) and the program loader/debug port (writes and reads).
- After reset it captures the program start address from the memory's first word and presents it to fetch as the initial PC.
- It then shares the memory port between fetch and loader, with bounded loader bursts so fetch is never starved.

Parameters:
- ADDR_BASE, 32'h0010_0000, byte address of the first memory word; it holds the start address.
- DEPTH_WORDS, 1025, number of 32-bit words in the memory.
- MAX_LD_BURST, 4, maximum consecutive loader grants while fetch_req is pending.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- fetch_req  in  1  fetch wants an instruction this cycle
- fetch_addr  in  32  fetch byte address
- fetch_grant  out  1  fetch request accepted this cycle
- fetch_valid  out  1  fetch_instr valid (one cycle after grant)
- fetch_instr  out  32  instruction word
- fetch_fault  out  1  granted fetch was misaligned or out of range
- ld_req  in  1  loader request
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  32  loader byte address
- ld_wdata  in  32  loader write data
- ld_grant  out  1  loader request accepted this cycle
- ld_rdata  out  32  loader read data, valid when ld_rvalid is 1
- ld_rvalid  out  1  loader read data valid (one cycle after grant)
- boot_done  out  1  start address captured, fetch may run
- start_pc  out  32  captured start address
- mem_addr  out  32  word index to memory (byte address >> 2)
- mem_we  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data (combinational from mem_addr)

Behaviour:
- Reset (async, reset_n = 0) forces every output to 0: all grants, valids and faults, boot_done, start_pc, mem_*, fetch_instr, ld_rdata. The FSM enters BOOT0 and the burst counter clears.
- FSM states and transitions:
  - BOOT0: one cycle idle so the memory's init cycle elapses; mem_addr = ADDR_BASE >> 2. Next state BOOT1.
  - BOOT1: drives mem_addr = ADDR_BASE >> 2 and registers mem_rdata into start_pc. Sets boot_done = 1 at the next edge. Next state RUN.
  - RUN: arbitrates fetch and loader every cycle. boot_done stays 1 until reset.
- In BOOT0 and BOOT1 both grants are 0; requests are ignored, not queued.
- Arbitration in RUN is combinational on the current cycle's requests, with grants asserted in the same cycle:
  - Loader has priority, unless the burst counter equals MAX_LD_BURST and fetch_req = 1; then fetch wins and the counter clears.
  - The counter increments on each loader grant while fetch_req = 1. It clears on any fetch grant or any cycle with fetch_req = 0. It saturates at MAX_LD_BURST.
  - At most one grant per cycle. A non-granted requester holds its request; it is not latched.
- Address check:
  - A fetch or loader address is bad if addr[1:0] != 0, addr < ADDR_BASE, or addr >= ADDR_BASE + 4*DEPTH_WORDS.
  - A bad fetch is still granted, but the memory is not accessed (mem_we = 0). Next cycle fetch_valid = 1, fetch_fault = 1, fetch_instr = 0.
  - A bad loader write is granted and dropped (mem_we stays 0). A bad loader read returns ld_rdata = 0 with ld_rvalid = 1.
- Latency:
  - Read data is registered. fetch_valid/fetch_instr and ld_rvalid/ld_rdata appear exactly one cycle after the grant; valid pulses are one cycle wide.
  - A loader write has mem_we = 1 in the grant cycle and produces no rvalid.
- Hazards:
  - A loader write to address A followed by a fetch of A on the next cycle returns the new data. No bypass is needed because the memory write completes at the edge.
  - A write to the ADDR_BASE word after boot does not change start_pc.
- Reset asserted mid-operation aborts any in-flight read: the valid is not produced and the FSM returns to BOOT0.

Test Plan:
- Boot: memory word0 = 32'h0040_0000 → boot_done rises exactly 2 cycles after reset_n deasserts; start_pc = 32'h0040_0000; no grants before then.
- Fetch only: fetch_req held with addresses 0x0010_0004, 0x0010_0008 → grant each cycle; fetch_instr equals the memory words one cycle later; fetch_fault = 0.
- Contention: fetch_req and ld_req both held continuously → grant pattern is 4 loader grants, 1 fetch grant, repeating. The counter never exceeds 4.
- Write-then-fetch: loader writes 32'hDEAD_BEEF to 0x0010_0010, fetch of 0x0010_0010 on the next cycle → fetch_instr = 32'hDEAD_BEEF.
- Faults: fetch at 0x0010_0002 and at 0x0000_0000 → granted, fetch_valid = 1, fetch_fault = 1, fetch_instr = 0, mem_we never asserted. Loader write to 0x0020_0000 → memory unchanged.
- Mid-read reset: assert reset_n = 0 in the cycle after a fetch grant → no fetch_valid; all outputs 0; boot repeats and start_pc is recaptured.
